// File: rtl/wb_writeback_stage.sv
// MEM/WB pipeline register and write-back mux: latches MEM results, extracts load data, selects the RF write value.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_writeback_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] RESET_PC4 = 32'h0000_0004
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_wb,
  input  logic            flush_wb,
  input  logic            valid_mem,
  input  logic            RegWrite_mem,
  input  logic [4:0]      WriteAddr_mem,
  input  logic [1:0]      MemtoReg_mem,
  input  logic [2:0]      funct3_mem,
  input  logic [XLEN-1:0] ALUResult_mem,
  input  logic [XLEN-1:0] ReadData_mem,
  input  logic [XLEN-1:0] PCPlus4_mem,
  output logic [XLEN-1:0] WriteData_wb,
  output logic [4:0]      WriteAddr_wb,
  output logic            RegWrite_wb,
  output logic            valid_wb
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     retire_cnt
`endif
);

  typedef struct packed {
    logic            vld;
    logic            rw;
    logic [4:0]      rd;
    logic [1:0]      m2r;
    logic [2:0]      f3;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] pc4;
  } mw_t;

  mw_t q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      q.pc4 <= RESET_PC4;
    end else if (flush_wb) begin
      // bubble: only the control bits matter, data fields keep their old value
      q.vld <= 1'b0;
      q.rw  <= 1'b0;
    end else if (!stall_wb) begin
      q.vld   <= valid_mem;
      q.rw    <= RegWrite_mem & valid_mem;
      q.rd    <= WriteAddr_mem;
      q.m2r   <= MemtoReg_mem;
      q.f3    <= funct3_mem;
      q.alu   <= ALUResult_mem;
      q.rdata <= ReadData_mem;
      q.pc4   <= PCPlus4_mem;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      retire_cnt <= '0;
    else if (!flush_wb && !stall_wb && valid_mem)
      retire_cnt <= retire_cnt + 64'd1;
  end
`endif

  logic [1:0]      off;
  logic [7:0]      lbyte;
  logic [15:0]     lhalf;
  logic [XLEN-1:0] ld_val;

  assign off   = q.alu[1:0];
  assign lbyte = q.rdata[8*off +: 8];
  assign lhalf = q.rdata[16*off[1] +: 16];

  always_comb begin
    ld_val = q.rdata;
    case (q.f3)
      3'b000:  ld_val = {{(XLEN-8){lbyte[7]}}, lbyte};
      3'b100:  ld_val = {{(XLEN-8){1'b0}}, lbyte};
      3'b001:  ld_val = {{(XLEN-16){lhalf[15]}}, lhalf};
      3'b101:  ld_val = {{(XLEN-16){1'b0}}, lhalf};
      default: ld_val = q.rdata;
    endcase
  end

  always_comb begin
    WriteData_wb = q.alu;
    case (q.m2r)
      2'b01:   WriteData_wb = ld_val;
      2'b10:   WriteData_wb = q.pc4;
      default: WriteData_wb = q.alu;
    endcase
  end

  assign WriteAddr_wb = q.rd;
  assign RegWrite_wb  = q.rw & q.vld & (q.rd != 5'd0);
  assign valid_wb     = q.vld;

endmodule

// File: doc/wb_writeback_stage.md
Name: wb_writeback_stage

Overview:
- MEM/WB pipeline register plus write-back datapath for the 32-bit pipelined RISC-V core.
- Captures MEM-stage results, extracts and extends load data, and selects the final write value.
- Drives the writer-side signals (WriteData_wb, WriteAddr_wb, RegWrite_wb) that the ID-stage register file uses for both its write port and its same-cycle bypass.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- RESET_PC4, 32'h0000_0004, reset value of the latched PC+4 field.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- stall_wb  input  1  hold the MEM/WB register contents.
- flush_wb  input  1  load a bubble instead of MEM-stage contents.
- valid_mem  input  1  MEM-stage slot holds a real instruction.
- RegWrite_mem  input  1  instruction writes rd.
- WriteAddr_mem  input  5  rd index.
- MemtoReg_mem  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 reserved (ALU).
- funct3_mem  input  3  load size/sign.
- ALUResult_mem  input  32  ALU result, or load effective address.
- ReadData_mem  input  32  raw aligned data-memory word.
- PCPlus4_mem  input  32  link value for JAL/JALR.
- WriteData_wb  output  32  value to write or bypass.
- WriteAddr_wb  output  5  destination register.
- RegWrite_wb  output  1  write enable; never asserted for x0.
- valid_wb  output  1  WB slot holds a real instruction.

Behaviour:
- Pipeline register updates on each rising clk edge. Priority: rst > flush_wb > stall_wb > normal load.
- rst=1: valid, RegWrite, and all data fields cleared to 0; PC+4 field set to RESET_PC4.
  - Resulting outputs: RegWrite_wb=0, WriteAddr_wb=0, WriteData_wb=0, valid_wb=0.
- flush_wb=1 (overrides stall): valid and RegWrite fields cleared; data fields don't-care but held.
- stall_wb=1 and flush_wb=0: all fields hold.
- Normal load: all *_mem fields captured. RegWrite field = RegWrite_mem & valid_mem.
- Latency: one cycle. An instruction present in MEM at edge N drives the WB outputs during cycle N+1.
- Outputs are combinational from the registered fields only; there is no combinational path from *_mem to *_wb.
- RegWrite_wb = RegWrite field & valid field & (WriteAddr field != 0).
- Load extraction uses the latched byte offset off = ALUResult[1:0]:
  - funct3 000 LB: byte[off], sign-extended.
  - funct3 100 LBU: byte[off], zero-extended.
  - funct3 001 LH: halfword[off[1]], sign-extended; off[0] ignored (misalignment is trapped upstream).
  - funct3 101 LHU: halfword[off[1]], zero-extended.
  - funct3 010 LW and funct3 011/110/111: full word passed unchanged.
- Byte lanes are little-endian: byte0 = bits[7:0].
- WriteData_wb select: MemtoReg 00/11 → ALU field; 01 → extracted load; 10 → PC+4 field.
- Stall held across many cycles: outputs constant. The register file may rewrite the same value each cycle; this is harmless.
- Flush and stall asserted in the same cycle: flush wins and a bubble is loaded.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined: adds output retire_cnt (64-bit).
  - Cleared by rst.
  - Increments by 1 on each edge where a valid, non-flushed, non-stalled instruction is loaded into WB.
  - Wraps from 2^64-1 to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: rst=1 for 2 cycles with random *_mem → RegWrite_wb=0, valid_wb=0, WriteData_wb=0, WriteAddr_wb=0.
- ALU write: RegWrite_mem=1, WriteAddr_mem=5, MemtoReg=00, ALUResult=32'h1234_5678 → next cycle RegWrite_wb=1, WriteAddr_wb=5, WriteData_wb=32'h1234_5678.
- Loads with ReadData=32'h80FF_7F01:
  - LB off=3 → FFFF_FF80.
  - LBU off=3 → 0000_0080.
  - LH off=2 → FFFF_80FF.
  - LHU off=0 → 0000_7F01.
  - LW → 80FF_7F01.
- x0 suppression: RegWrite_mem=1, WriteAddr_mem=0, ALUResult=7 → RegWrite_wb=0.
- Stall/flush:
  - Load instr A (rd=3), then stall 3 cycles with B at MEM → outputs stay A.
  - Then flush+stall together → next cycle RegWrite_wb=0, valid_wb=0.
- JAL link and counter: MemtoReg=10, PCPlus4=32'h0000_0104, rd=1 → WriteData_wb=32'h0000_0104.
  - With WB_RETIRE_CNT_EN: after 4 valid loads, 1 flushed and 2 stalled cycles, retire_cnt=4.
